// File: rtl/uart_cmd_rcv.sv
// rtl/uart_cmd_rcv.sv - 3-byte UART command frame receiver with 1-byte response transmitter
// Receiver, frame decoder and transmitter run independently; cmd/data publish atomically with cmd_rdy.
module uart_cmd_rcv #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int CW = $clog2(TIMEOUT_BITS * BAUD_DIV + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_BITS * BAUD_DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {F_IDLE, F_HIGH, F_LOW} fr_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_done, frame_err;

  fr_state_e     fr_state_q, fr_state_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout;
  logic [7:0]    cmd_sh_q, cmd_sh_d, hi_sh_q, hi_sh_d, cmd_q, cmd_d;
  logic [15:0]   data_q, data_d;
  logic          cmd_rdy_q, cmd_rdy_d;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          resp_sent_q, resp_sent_d;

  // Synchronizer flops reset high so a reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_q <= R_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
      R_START: if (rx_cnt_q == HALF_END) rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
      R_DATA:  if (rx_cnt_q == BIT_END && rx_bit_q == 3'd7) rx_state_d = R_STOP;
      R_STOP:  if (rx_cnt_q == BIT_END) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
      end
      R_START: if (rx_cnt_q == HALF_END) rx_cnt_d = '0;
      R_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
      end
      R_STOP: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d  = '0;
        byte_done = rx_sync_q;
        frame_err = !rx_sync_q;
      end
      default: rx_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Inter-byte gap only counts while the receiver is idle; a start bit in progress stops it.
  assign timeout = (fr_state_q != F_IDLE) && (rx_state_q == R_IDLE) && (to_cnt_q == TO_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fr_state_q <= F_IDLE;
    else     fr_state_q <= fr_state_d;
  end

  always_comb begin
    fr_state_d = fr_state_q;
    if (frame_err || timeout) begin
      fr_state_d = F_IDLE;
    end else if (byte_done) begin
      case (fr_state_q)
        F_IDLE:  fr_state_d = F_HIGH;
        F_HIGH:  fr_state_d = F_LOW;
        default: fr_state_d = F_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_sh_d  = cmd_sh_q;
    hi_sh_d   = hi_sh_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q;
    to_cnt_d  = (fr_state_q == F_IDLE || rx_state_q != R_IDLE || timeout) ? '0 : to_cnt_q + 1'b1;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (byte_done) begin
      case (fr_state_q)
        F_IDLE: begin
          cmd_sh_d  = rx_shift_q;
          cmd_rdy_d = 1'b0;
        end
        F_HIGH: hi_sh_d = rx_shift_q;
        default: begin
          cmd_d     = cmd_sh_q;
          data_d    = {hi_sh_q, rx_shift_q};
          cmd_rdy_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      cmd_sh_q  <= '0;
      hi_sh_q   <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      cmd_sh_q  <= cmd_sh_d;
      hi_sh_q   <= hi_sh_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = cmd_rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= T_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE:  if (send_resp) tx_state_d = T_START;
      T_START: if (tx_cnt_q == BIT_END) tx_state_d = T_DATA;
      T_DATA:  if (tx_cnt_q == BIT_END && tx_bit_q == 3'd7) tx_state_d = T_STOP;
      T_STOP:  if (tx_cnt_q == BIT_END) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Line level and busy decode straight from state so reset forces TX high without a clock.
  always_comb begin
    tx_cnt_d    = tx_cnt_q + 1'b1;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    resp_sent_d = 1'b0;
    TX          = 1'b1;
    tx_busy     = 1'b1;
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_busy  = 1'b0;
        if (send_resp) tx_byte_d = resp;
      end
      T_START: begin
        TX = 1'b0;
        if (tx_cnt_q == BIT_END) tx_cnt_d = '0;
      end
      T_DATA: begin
        TX = tx_byte_q[tx_bit_q];
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      T_STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d    = '0;
        resp_sent_d = 1'b1;
      end
      default: tx_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb/tb_uart_cmd_rcv.sv - directed self-checking bench for uart_cmd_rcv
module tb_uart_cmd_rcv;

  localparam int B  = 16;
  localparam int H  = B / 2;
  localparam int TB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;

  int total = 0;
  int bad   = 0;

  uart_cmd_rcv #(.BAUD_DIV(B), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (B) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v[i]);
    drive_bit(stop);
  endtask

  // Stop sample lands H+3 clocks into the stop bit; cmd_rdy must rise exactly there.
  task automatic send_last(input logic [7:0] v, input logic clr_on_set);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v[i]);
    RX = 1'b1;
    repeat (H + 2) @(posedge clk);
    @(negedge clk);
    check("rdy_before_stop_sample", cmd_rdy, 0);
    clr_cmd_rdy = clr_on_set;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("rdy_after_stop_sample", cmd_rdy, 1);
    repeat (B - H - 3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic clr_on_set);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_last(c, clr_on_set);
  endtask

  logic [9:0] tx_exp;

  initial begin
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
    #2;
    check("rst_TX", TX, 1);
    check("rst_cmd", cmd, 8'h00);
    check("rst_data", data, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_resp_sent", resp_sent, 0);
    check("rst_tx_busy", tx_busy, 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    idle(2 * B);

    send_frame(8'h08, 8'h04, 8'h20, 1'b0);
    check("f1_cmd", cmd, 8'h08);
    check("f1_data", data, 16'h0420);

    send_byte(8'h06, 1'b1);
    check("f2_first_byte_rdy", cmd_rdy, 0);
    check("f2_first_byte_cmd_hold", cmd, 8'h08);
    check("f2_first_byte_data_hold", data, 16'h0420);
    send_byte(8'hF0, 1'b1);
    send_last(8'hF0, 1'b1);
    check("f2_cmd", cmd, 8'h06);
    check("f2_data", data, 16'hF0F0);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    check("clr_rdy", cmd_rdy, 0);
    check("clr_cmd_hold", cmd, 8'h06);

    resp = 8'hA5;
    tx_exp = 10'b11_1010_0101 << 1;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    check("tx_busy_start", tx_busy, 1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d_first", k), TX, tx_exp[k]);
      send_resp = (k == 3);
      resp = (k == 3) ? 8'hFF : 8'hA5;
      @(posedge clk);
      #1 send_resp = 1'b0;
      repeat (B - 2) @(posedge clk);
      @(negedge clk);
      check($sformatf("tx_bit%0d_last", k), TX, tx_exp[k]);
      if (k == 9) begin
        check("tx_busy_last_clk", tx_busy, 1);
        check("resp_sent_early", resp_sent, 0);
      end
      @(posedge clk);
      #1;
    end
    check("tx_busy_end", tx_busy, 0);
    check("resp_sent_pulse", resp_sent, 1);
    check("tx_idle_line", TX, 1);
    @(posedge clk);
    #1 check("resp_sent_once", resp_sent, 0);

    send_byte(8'h08, 1'b0);
    idle(2 * B);
    check("ferr_rdy", cmd_rdy, 0);
    check("ferr_cmd_hold", cmd, 8'h06);
    send_frame(8'h08, 8'h12, 8'h34, 1'b0);
    check("ferr_cmd", cmd, 8'h08);
    check("ferr_data", data, 16'h1234);

    send_byte(8'h08, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(200);
    check("to_rdy", cmd_rdy, 0);
    check("to_cmd_hold", cmd, 8'h08);
    check("to_data_hold", data, 16'h1234);
    send_frame(8'h06, 8'hAB, 8'hCD, 1'b0);
    check("to_cmd", cmd, 8'h06);
    check("to_data", data, 16'hABCD);

    send_byte(8'h08, 1'b1);
    idle(100);
    send_byte(8'h11, 1'b1);
    idle(100);
    send_last(8'h22, 1'b0);
    check("gap_ok_cmd", cmd, 8'h08);
    check("gap_ok_data", data, 16'h1122);

    RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(12 * B);
    check("glitch_rdy_hold", cmd_rdy, 1);
    send_frame(8'h11, 8'h22, 8'h33, 1'b0);
    check("glitch_cmd", cmd, 8'h11);
    check("glitch_data", data, 16'h2233);

    send_byte(8'h55, 1'b1);
    resp = 8'h3C;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("pre_rst_tx_busy", tx_busy, 1);
    check("pre_rst_cmd", cmd, 8'h11);
    #3;
    rst = 1'b1;
    RX = 1'b1;
    #1;
    check("mid_rst_TX", TX, 1);
    check("mid_rst_tx_busy", tx_busy, 0);
    check("mid_rst_cmd", cmd, 8'h00);
    check("mid_rst_data", data, 16'h0000);
    check("mid_rst_cmd_rdy", cmd_rdy, 0);
    check("mid_rst_resp_sent", resp_sent, 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    idle(2 * B);
    send_frame(8'h02, 8'h00, 8'h01, 1'b0);
    check("post_rst_cmd", cmd, 8'h02);
    check("post_rst_data", data, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rcv.md
UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

Copter-side endpoint of the wireless command link. It receives 3-byte command frames (cmd, data[15:8], data[7:0]) and returns a 1-byte response.

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per bit (19200 baud at 50 MHz).
REQ-002 Parameter TIMEOUT_BITS, default 40, maximum bit-times of idle allowed between bytes of one frame.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RX  input  1  serial in, idle high, asynchronous to clk.
REQ-006 TX  output  1  serial out, idle high.
REQ-007 cmd  output  8  command byte of last complete frame.
REQ-008 data  output  16  data word of last complete frame.
REQ-009 cmd_rdy  output  1  complete frame available.
REQ-010 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-011 resp  input  8  response byte to transmit.
REQ-012 send_resp  input  1  single-cycle request to transmit resp.
REQ-013 resp_sent  output  1  one-cycle pulse when the response stop bit completes.
REQ-014 tx_busy  output  1  high while a response is being shifted out.

Function
REQ-015 RX shall pass through a two-flop synchronizer whose flops reset to 1.
REQ-016 The receiver shall detect a start bit on a synchronized high-to-low transition while idle, then sample at BAUD_DIV/2 and every BAUD_DIV clocks thereafter: start, 8 data bits LSB first, stop.
REQ-017 If the start bit re-samples high at mid-bit, the receiver shall treat it as a glitch and return to idle with no byte produced.
REQ-018 If the stop bit samples low, the receiver shall discard the byte as a framing error and force the frame FSM to IDLE.
REQ-019 Frame FSM states and transitions shall be:
- IDLE --byte--> HIGH: capture cmd.
- HIGH --byte--> LOW: capture data[15:8].
- LOW --byte--> IDLE: capture data[7:0] and set cmd_rdy.
REQ-020 Captures shall go to shadow registers; cmd and data outputs shall update together, in the same cycle that cmd_rdy sets.
REQ-021 cmd_rdy shall assert on the clock following the third byte's stop-bit sample.
REQ-022 cmd_rdy shall hold until clr_cmd_rdy is sampled high, or until the first byte of the next frame completes.
REQ-023 If setting cmd_rdy and clr_cmd_rdy coincide, set shall win.
REQ-024 In HIGH or LOW, if no start bit arrives within TIMEOUT_BITS*BAUD_DIV clocks of the previous stop sample, the FSM shall return to IDLE, discarding partial bytes; cmd, data and cmd_rdy shall be unchanged.
REQ-025 The outputs cmd and data shall hold their values until the next complete frame.
REQ-026 On send_resp while tx_busy=0, the transmitter shall latch resp and assert tx_busy the next clock.
REQ-027 The transmitter shall drive start 0, resp LSB first, then stop 1, each for exactly BAUD_DIV clocks.
REQ-028 At the end of the stop bit, the transmitter shall clear tx_busy and pulse resp_sent for one cycle.
REQ-029 send_resp while tx_busy=1 shall be ignored; the latched byte shall not change.
REQ-030 Receiver and transmitter shall operate concurrently and independently (full duplex).
REQ-031 Baud counters shall be sized ceil(log2(TIMEOUT_BITS*BAUD_DIV+1)) bits and shall never wrap mid-bit.

Reset
REQ-032 On rst, without waiting for a clock edge:
- TX=1, cmd=0x00, data=0x0000, cmd_rdy=0, resp_sent=0, tx_busy=0.
- Frame FSM to IDLE; receiver and transmitter idle.
REQ-033 Reset asserted mid-frame or mid-transmit shall abort the operation; the first full frame after release shall decode correctly.

Verification
REQ-034 Frame 0x08,0x04,0x20 -> cmd=0x08, data=0x0420, cmd_rdy=1 one clock after the third stop sample; then clr_cmd_rdy -> cmd_rdy=0 next clock.
REQ-035 Frame 0x06,0xF0,0xF0 with cmd_rdy still set from the prior frame -> cmd_rdy drops at the first byte and re-asserts with cmd=0x06, data=0xF0F0; clr_cmd_rdy pulsed on the set cycle -> cmd_rdy stays 1.
REQ-036 send_resp with resp=0xA5 -> TX = 0,1,0,1,0,0,1,0,1,1, each 2604 clocks; resp_sent pulses once; tx_busy=1 for 26040 clocks; a second send_resp mid-transfer is ignored.
REQ-037 Byte 0x08 with stop bit forced low, then valid frame 0x08,0x12,0x34 -> no cmd_rdy for the bad byte; cmd=0x08, data=0x1234 after the good frame.
REQ-038 Bytes 0x08,0x04, then idle beyond the timeout, then 0x06,0xAB,0xCD -> cmd=0x06, data=0xABCD, no stale bytes.
REQ-039 rst pulsed during the second byte -> all outputs at reset values immediately; the following frame 0x02,0x00,0x01 -> cmd=0x02, data=0x0001.
